// File: rtl/note_history_display.sv
// Four-symbol scrolling note history for the seven-segment driver, with a
// follow-on accidental symbol, a saturating note counter, idle-timeout and clear blanking.
module note_history_display #(
  parameter int unsigned IDLE_CYCLES = 200000000,
  parameter int unsigned CNT_W       = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        note_valid,
  input  logic [2:0]  note_idx,
  input  logic [1:0]  accidental,
  input  logic        clear,
  output logic        note_ready,
  output logic [15:0] nums,
  output logic        blank,
  output logic [7:0]  note_count
);

  localparam logic [0:0]       S_IDLE    = 1'b0;
  localparam logic [0:0]       S_ACC     = 1'b1;
  localparam logic [15:0]      DASHES    = 16'h9999;
  localparam logic [3:0]       SYM_SHARP = 4'd7;
  localparam logic [3:0]       SYM_FLAT  = 4'd8;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [3:0]       acc_sym;
  logic [CNT_W-1:0] idle_cnt;
  logic             accept;
  logic             push;
  logic             timeout;
  logic [3:0]       push_sym;

  assign note_ready = (state == S_IDLE);

  // Next state plus the push/timeout decisions for this edge
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    push       = 1'b0;
    push_sym   = 4'd0;
    timeout    = 1'b0;
    case (state)
      S_IDLE: begin
        accept = note_valid && (note_idx != 3'd7);
        if (accept) begin
          push     = 1'b1;
          push_sym = {1'b0, note_idx};
          if (accidental == 2'd1 || accidental == 2'd2) state_next = S_ACC;
        end else if (!blank && idle_cnt == IDLE_LAST) begin
          timeout = 1'b1;
        end
      end
      S_ACC: begin
        push       = 1'b1;
        push_sym   = acc_sym;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (clear) state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // History shift register, blank flag, idle counter and note counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nums       <= DASHES;
      blank      <= 1'b1;
      note_count <= 8'd0;
      idle_cnt   <= '0;
      acc_sym    <= SYM_SHARP;
    end else if (clear) begin
      nums       <= DASHES;
      blank      <= 1'b1;
      note_count <= 8'd0;
      idle_cnt   <= '0;
    end else begin
      if (push) begin
        nums     <= {nums[11:0], push_sym};
        blank    <= 1'b0;
        idle_cnt <= '0;
      end else if (timeout) begin
        nums     <= DASHES;
        blank    <= 1'b1;
        idle_cnt <= '0;
      end else if (!blank) begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end
      if (accept) begin
        if (note_count != 8'hFF) note_count <= note_count + 8'd1;
        acc_sym <= (accidental == 2'd2) ? SYM_FLAT : SYM_SHARP;
      end
    end
  end

endmodule

// File: tb/tb_note_history_display.sv
// Self-checking bench for note_history_display: directed scenarios plus
// randomized traffic against a history/age-based reference model.
module tb_note_history_display;

  localparam int unsigned IDLE = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        note_valid;
  logic [2:0]  note_idx;
  logic [1:0]  accidental;
  logic        clear;
  logic        note_ready;
  logic [15:0] nums;
  logic        blank;
  logic [7:0]  note_count;

  int errors = 0;
  int checks = 0;

  // Reference model: newest symbol at index 0, age since last push
  logic [3:0] m_hist [4];
  logic       m_blank;
  int         m_count;
  int         m_pend;
  int         m_age;

  note_history_display #(.IDLE_CYCLES(IDLE), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .note_valid(note_valid), .note_idx(note_idx),
    .accidental(accidental), .clear(clear), .note_ready(note_ready),
    .nums(nums), .blank(blank), .note_count(note_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_nums();
    return {m_hist[3], m_hist[2], m_hist[1], m_hist[0]};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_hist[i] = 4'd9;
    m_blank = 1'b1; m_count = 0; m_pend = 0; m_age = 0;
  endtask

  task automatic m_push(input int sym);
    for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = 4'(sym);
    m_blank = 1'b0; m_age = 0;
  endtask

  task automatic m_step(input logic nv, input int idx, input int acc, input logic clr);
    if (clr) begin
      m_reset();
    end else if (m_pend != 0) begin
      m_push(m_pend); m_pend = 0;
    end else if (nv && idx < 7) begin
      m_push(idx);
      if (m_count < 255) m_count++;
      m_pend = (acc == 1) ? 7 : (acc == 2) ? 8 : 0;
    end else if (!m_blank) begin
      m_age++;
      if (m_age == IDLE) begin
        for (int i = 0; i < 4; i++) m_hist[i] = 4'd9;
        m_blank = 1'b1; m_age = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model, settle past the edge
  task automatic step(input logic nv, input int idx, input int acc, input logic clr);
    note_valid = nv; note_idx = 3'(idx); accidental = 2'(acc); clear = clr;
    @(posedge clk);
    m_step(nv, idx, acc, clr);
    #1;
    note_valid = 1'b0; note_idx = 3'd0; accidental = 2'd0; clear = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; #2;
    m_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    step(1'b1, 2, 1, 1'b0);
    #3 rst = 1'b1; #1;
    m_reset();
    checks++;
    if (nums !== 16'h9999 || blank !== 1'b1 || note_ready !== 1'b1 || note_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_async: nums=%h blank=%b ready=%b count=%0d, want 9999 1 1 0",
               nums, blank, note_ready, note_count);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (nums !== 16'h9999 || blank !== 1'b1 || note_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: nums=%h blank=%b ready=%b, want 9999 1 1", nums, blank, note_ready);
    end
  endtask

  task automatic test_naturals();
    int idx [4] = '{0, 2, 4, 5};
    logic [15:0] exp [4] = '{16'h9990, 16'h9902, 16'h9024, 16'h0245};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (note_ready !== 1'b1) begin
        errors++; $display("FAIL naturals_ready[%0d]: ready=%b, want 1", i, note_ready);
      end
      step(1'b1, idx[i], 0, 1'b0);
      checks++;
      if (nums !== exp[i] || blank !== 1'b0) begin
        errors++; $display("FAIL naturals_nums[%0d]: nums=%h blank=%b, want %h 0", i, nums, blank, exp[i]);
      end
    end
    checks++;
    if (note_count !== 8'd4 || note_ready !== 1'b1) begin
      errors++; $display("FAIL naturals_count: count=%0d ready=%b, want 4 1", note_count, note_ready);
    end
  endtask

  task automatic test_accidentals();
    do_reset();
    step(1'b1, 3, 1, 1'b0);
    checks++;
    if (nums !== 16'h9993 || note_ready !== 1'b0) begin
      errors++; $display("FAIL sharp_note: nums=%h ready=%b, want 9993 0", nums, note_ready);
    end
    step(1'b0, 0, 0, 1'b0);
    checks++;
    if (nums !== 16'h9937 || note_ready !== 1'b1) begin
      errors++; $display("FAIL sharp_sym: nums=%h ready=%b, want 9937 1", nums, note_ready);
    end
    step(1'b1, 6, 2, 1'b0);
    checks++;
    if (nums !== 16'h9376 || note_ready !== 1'b0) begin
      errors++; $display("FAIL flat_note: nums=%h ready=%b, want 9376 0", nums, note_ready);
    end
    step(1'b1, 5, 0, 1'b0);
    checks++;
    if (nums !== 16'h3768 || note_ready !== 1'b1) begin
      errors++; $display("FAIL flat_sym: nums=%h ready=%b, want 3768 1", nums, note_ready);
    end
    step(1'b0, 0, 0, 1'b0);
    checks++;
    if (nums !== 16'h3768 || note_count !== 8'd2) begin
      errors++; $display("FAIL dropped_note: nums=%h count=%0d, want 3768 2", nums, note_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step(1'b1, 1, 0, 1'b0);
    for (int i = 1; i < IDLE; i++) begin
      step(1'b0, 0, 0, 1'b0);
      checks++;
      if (nums !== 16'h9991 || blank !== 1'b0) begin
        errors++; $display("FAIL timeout_hold[%0d]: nums=%h blank=%b, want 9991 0", i, nums, blank);
      end
    end
    step(1'b0, 0, 0, 1'b0);
    checks++;
    if (nums !== 16'h9999 || blank !== 1'b1 || note_count !== 8'd1) begin
      errors++; $display("FAIL timeout_blank: nums=%h blank=%b count=%0d, want 9999 1 1", nums, blank, note_count);
    end
    step(1'b1, 1, 0, 1'b0);
    for (int i = 1; i < IDLE; i++) step(1'b0, 0, 0, 1'b0);
    step(1'b1, 4, 0, 1'b0);
    checks++;
    if (nums !== 16'h9914 || blank !== 1'b0) begin
      errors++; $display("FAIL timeout_accept_wins: nums=%h blank=%b, want 9914 0", nums, blank);
    end
    for (int i = 1; i < IDLE; i++) step(1'b0, 0, 0, 1'b0);
    checks++;
    if (nums !== 16'h9914 || blank !== 1'b0) begin
      errors++; $display("FAIL timeout_restart: nums=%h blank=%b, want 9914 0", nums, blank);
    end
    step(1'b0, 0, 0, 1'b0);
    checks++;
    if (nums !== 16'h9999 || blank !== 1'b1) begin
      errors++; $display("FAIL timeout_second: nums=%h blank=%b, want 9999 1", nums, blank);
    end
  endtask

  task automatic test_clear();
    do_reset();
    step(1'b1, 4, 1, 1'b0);
    step(1'b1, 2, 0, 1'b1);
    checks++;
    if (nums !== 16'h9999 || blank !== 1'b1 || note_count !== 8'd0 || note_ready !== 1'b1) begin
      errors++; $display("FAIL clear_in_acc: nums=%h blank=%b count=%0d ready=%b, want 9999 1 0 1",
                         nums, blank, note_count, note_ready);
    end
    step(1'b1, 7, 0, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    checks++;
    if (nums !== 16'h9999 || blank !== 1'b1 || note_count !== 8'd0) begin
      errors++; $display("FAIL invalid_note: nums=%h blank=%b count=%0d, want 9999 1 0", nums, blank, note_count);
    end
  endtask

  task automatic test_saturation();
    int seq [300];
    logic [15:0] exp;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      seq[i] = int'($urandom_range(6, 0));
      step(1'b1, seq[i], ($urandom_range(1, 0) == 0) ? 0 : 3, 1'b0);
    end
    exp = {4'(seq[296]), 4'(seq[297]), 4'(seq[298]), 4'(seq[299])};
    checks++;
    if (note_count !== 8'd255 || nums !== exp) begin
      errors++; $display("FAIL saturation: count=%0d nums=%h, want 255 %h", note_count, nums, exp);
    end
  endtask

  task automatic test_random();
    logic nv, clr;
    int idx, acc;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      nv  = ($urandom_range(2, 0) != 0);
      idx = int'($urandom_range(7, 0));
      acc = int'($urandom_range(3, 0));
      clr = ($urandom_range(39, 0) == 0);
      if (i % 50 > 30) nv = 1'b0;
      checks++;
      if (note_ready !== (m_pend == 0)) begin
        errors++; $display("FAIL random_ready[%0d]: ready=%b, want %b", i, note_ready, m_pend == 0);
      end
      step(nv, idx, acc, clr);
      checks++;
      if (nums !== m_nums() || blank !== m_blank || note_count !== 8'(m_count)) begin
        errors++; $display("FAIL random_state[%0d]: nums=%h blank=%b count=%0d, want %h %b %0d",
                           i, nums, blank, note_count, m_nums(), m_blank, m_count);
      end
    end
  endtask

  initial begin
    rst = 1'b1; note_valid = 1'b0; note_idx = 3'd0; accidental = 2'd0; clear = 1'b0;
    m_reset();
    do_reset();
    test_reset();
    test_naturals();
    test_accidentals();
    test_timeout();
    test_clear();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/note_history_display.md
Name: note_history_display

Overview:
- Sits directly upstream of the seven-segment driver.
- Accepts note events from the keyboard/piano logic (one_pulse-conditioned strobes) and keeps a 4-symbol scrolling history of played notes and accidentals.
- Drives the driver's 16-bit `nums` input using the display symbol codes: 0=C, 1=D, 2=E, 3=F, 4=G, 5=A, 6=B, 7=sharp, 8=flat, 9=dash.
- Blanks to dashes after an idle timeout or on a clear pulse.

Parameters:
- IDLE_CYCLES, default 200000000: clk cycles with no symbol push before the display blanks (2 s at 100 MHz).
- CNT_W, default 28: width of the idle counter; must satisfy 2^CNT_W > IDLE_CYCLES.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  reset; asynchronous, active-high
- note_valid  input  1  single-cycle note event strobe
- note_idx  input  3  note, 0..6 = C..B; 7 is invalid
- accidental  input  2  0=natural, 1=sharp, 2=flat, 3=treated as natural
- clear  input  1  single-cycle strobe; blanks the display
- note_ready  output  1  high when a note event will be accepted this cycle
- nums  output  16  four 4-bit symbol codes; nums[3:0] is the newest/rightmost
- blank  output  1  high when nums == 16'h9999 because of reset, clear or timeout
- note_count  output  8  saturating count of accepted valid notes since reset/clear

Behaviour:
- Reset, asynchronous on rst high:
  - nums=16'h9999, blank=1, note_count=0.
  - State=S_IDLE, idle counter=0, note_ready=1.
- Release is synchronous to the clk edge.
- FSM states:
  - S_IDLE: note_ready=1.
  - S_ACC: note_ready=0, one cycle long.
  - note_ready is decoded from the state only (no combinational path from inputs).
- Push operation: nums <= {nums[11:0], sym}. The oldest symbol nums[15:12] is discarded. Push also sets blank=0 and clears the idle counter.
- Accept rule: in S_IDLE with note_valid=1 and note_idx<=6, on the clk edge:
  - Push sym=note_idx (zero-extended to 4 bits).
  - note_count increments, saturating at 255.
  - If accidental==1 or 2, go to S_ACC; otherwise stay in S_IDLE.
- S_ACC: on the next edge, push 7 (sharp) or 8 (flat), as latched at accept time, and return to S_IDLE. Inputs other than clear/rst are ignored in this cycle.
- Latency: note symbol is visible on nums 1 cycle after the accepting edge; accidental symbol 1 cycle later.
- Invalid note_idx==7 with note_valid: ignored entirely. No push, no count change, idle counter unaffected.
- note_valid while note_ready=0: dropped silently. Upstream must respect note_ready.
- Idle timeout:
  - In S_IDLE with blank=0 and no push, the counter increments each cycle.
  - On the edge where the counter == IDLE_CYCLES-1 and no accept occurs: nums<=16'h9999, blank<=1, counter<=0.
  - Net effect: nums blanks exactly IDLE_CYCLES cycles after the last push edge.
  - While blank=1 the counter holds at 0.
  - note_count is not affected by timeout.
- Simultaneous events:
  - clear has top priority after rst. On the edge: nums=16'h9999, blank=1, note_count=0, state=S_IDLE, counter=0. Any concurrent note_valid is dropped, and a pending S_ACC accidental is discarded.
  - An accept in the same cycle as the timeout terminal count: the accept wins. The push occurs and the counter goes to 0; no blanking.
- Reset mid-S_ACC: state returns to S_IDLE immediately and the pending accidental is lost.
- Partial history after blank: push shifts into dashes, so nums reads 9,9,9,sym until more notes arrive.
- All outputs are registered except note_ready, which is a state decode.

Test Plan (bench uses IDLE_CYCLES=8, CNT_W=4):
- Reset then idle: assert rst mid-cycle -> nums=16'h9999, blank=1, note_ready=1, note_count=0 immediately, without waiting for a clk edge.
- Naturals: pulse notes C, E, G, A (idx 0, 2, 4, 5, acc 0) on four consecutive cycles -> after each edge nums = 16'h9990, 16'h9902, 16'h9024, 16'h0245. note_count=4. note_ready never drops.
- Sharp/flat: pulse F#, idx 3 acc 1 -> nums=16'h9993, then next cycle 16'h9937 with note_ready=0 for exactly that cycle. Pulse Bb (idx 6, acc 2) -> 16'h9376 then 16'h3768. A note_valid during a note_ready=0 cycle is dropped: nums is unchanged beyond 16'h3768 and note_count=2.
- Timeout: push D (idx 1), then no input -> nums=16'h9991 for 8 cycles, then 16'h9999 with blank=1. Repeat with a new push on the terminal-count cycle -> no blank; nums shifts normally.
- Clear priority: during S_ACC after pushing G#, assert clear -> nums=16'h9999, note_count=0, state=S_IDLE, no 7 pushed. Pulse note_valid with idx 7 -> no change.
- Saturation: 300 accepted natural notes -> note_count=255, and nums holds the last 4 symbols.
